// File: rtl/counter_run_arbiter.sv
// Round-robin owner of a shared free-running counter: grants one client a timed run,
// holds the counter in reset while idle, and pulses done when the count reaches len.
module counter_run_arbiter #(
   parameter int Size       = 5,
   parameter int Requesters = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [Requesters-1:0]      req,
   input  logic [Requesters*Size-1:0] len,
   output logic [Requesters-1:0]      grant,
   output logic [Requesters-1:0]      done,
   output logic                       busy,
   output logic                       cnt_reset,
   input  logic [Size-1:0]            cnt_count,
   output logic [1:0]                 dbg_state
);
   localparam int IdxW = (Requesters > 1) ? $clog2(Requesters) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [Requesters-1:0] ONE = {{(Requesters-1){1'b0}}, 1'b1};

   // Handshake: req is a level a client holds until it sees its done pulse or gives up;
   // grant marks the owner from the first run cycle through the done cycle inclusive.
   logic [1:0]            state_q, state_d;
   logic [IdxW-1:0]       last_q, last_d;
   logic [IdxW-1:0]       owner_q, owner_d;
   logic [Size-1:0]       len_q, len_d;
   logic [Requesters-1:0] grant_q, grant_d;
   logic [Requesters-1:0] done_q, done_d;
   logic                  cnt_reset_q, cnt_reset_d;
   logic                  found;
   logic [IdxW-1:0]       pick;
   logic [IdxW-1:0]       idx;
   logic [Size-1:0]       len_arr [Requesters];

   always_comb begin
      for (int i = 0; i < Requesters; i++) begin
         len_arr[i] = len[i*Size +: Size];
      end
   end

   // Search starts just after the previous owner, so the last winner ranks lowest.
   always_comb begin
      found = 1'b0;
      pick  = last_q;
      idx   = '0;
      for (int k = 1; k <= Requesters; k++) begin
         idx = IdxW'((int'(last_q) + k) % Requesters);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      len_d       = len_q;
      grant_d     = grant_q;
      done_d      = done_q;
      cnt_reset_d = cnt_reset_q;
      case (state_q)
         IDLE: begin
            grant_d     = '0;
            done_d      = '0;
            cnt_reset_d = 1'b1;
            if (found) begin
               state_d     = RUN;
               grant_d     = ONE << pick;
               owner_d     = pick;
               last_d      = pick;
               len_d       = len_arr[pick];
               cnt_reset_d = 1'b0;
            end
         end
         RUN: begin
            // An abort wins over a length match on the same edge.
            if (!req[owner_q]) begin
               state_d     = IDLE;
               grant_d     = '0;
               cnt_reset_d = 1'b1;
            end else if (cnt_count == len_q) begin
               state_d     = DONE;
               done_d      = grant_q;
               cnt_reset_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            done_d  = '0;
            grant_d = '0;
         end
         default: begin
            state_d     = IDLE;
            grant_d     = '0;
            done_d      = '0;
            cnt_reset_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= IdxW'(Requesters - 1);
         owner_q     <= '0;
         len_q       <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         cnt_reset_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         len_q       <= len_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         cnt_reset_q <= cnt_reset_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign cnt_reset = cnt_reset_q;
   assign dbg_state = state_q;
endmodule

// File: tb/tb_counter_run_arbiter.sv
// Bench for counter_run_arbiter: shared counter model, run-level reference model,
// event scoreboard for grants and done pulses, directed phases then random traffic.
module tb_counter_run_arbiter;
   localparam int S  = 5;
   localparam int R  = 4;
   localparam int EW = 1 + 3 + S;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [R-1:0]   req = '0;
   logic [R*S-1:0] len = '0;
   logic [R-1:0]   grant, done;
   logic           busy, cnt_reset;
   logic [S-1:0]   cnt_count = '0;
   logic [1:0]     dbg_state;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_seen = 0;
   logic [EW-1:0] exp_q[$];
   int grant_log[$];

   counter_run_arbiter #(.Size(S), .Requesters(R)) dut (
      .clock(clock), .reset(reset), .req(req), .len(len),
      .grant(grant), .done(done), .busy(busy), .cnt_reset(cnt_reset),
      .cnt_count(cnt_count), .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   // The shared counter the block sits beside.
   always @(posedge clock) cnt_count <= cnt_reset ? '0 : cnt_count + 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event at cycle %0d", name, cyc);
   endtask

   function automatic int oh_idx(input logic [R-1:0] v);
      for (int i = 0; i < R; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Reference model: one run = grant, then done len+1 cycles later unless req drops.
   int m_owner = -1;
   int m_last = R - 1;
   int m_len = 0;
   int m_elapsed = 0;
   bit m_done_ph = 1'b0;
   logic [R-1:0] m_grant = '0;
   logic [R-1:0] m_done = '0;
   logic m_cnt_reset = 1'b1;

   always @(posedge clock) begin
      if (reset) begin
         m_owner = -1; m_last = R - 1; m_done_ph = 1'b0;
         m_grant = '0; m_done = '0; m_cnt_reset = 1'b1;
      end else if (m_done_ph) begin
         m_done_ph = 1'b0; m_owner = -1;
         m_grant = '0; m_done = '0; m_cnt_reset = 1'b1;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= R; k++)
            if (m_owner < 0 && req[(m_last + k) % R]) m_owner = (m_last + k) % R;
         if (m_owner >= 0) begin
            m_last = m_owner;
            m_len = int'(len[m_owner*S +: S]);
            m_elapsed = 0;
            m_grant = R'(1) << m_owner;
            m_cnt_reset = 1'b0;
            exp_q.push_back({1'b0, 3'(m_owner), S'(m_len)});
         end
      end else if (!req[m_owner]) begin
         m_owner = -1; m_grant = '0; m_cnt_reset = 1'b1;
      end else if (m_elapsed == m_len) begin
         m_done_ph = 1'b1; m_done = m_grant; m_cnt_reset = 1'b1;
         exp_q.push_back({1'b1, 3'(m_owner), S'(m_len)});
      end else begin
         m_elapsed++;
      end
   end

   // Monitor: per-cycle outputs against the model, grant/done events against the queue.
   logic [R-1:0]  prev_grant = '0;
   logic [S-1:0]  prev_cnt = '0;
   logic [EW-1:0] e;
   int grant_cyc [R];
   int gi, di;

   always @(negedge clock) begin
      cyc++;
      check("grant", 32'(grant), 32'(m_grant));
      check("done", 32'(done), 32'(m_done));
      check("cnt_reset", 32'(cnt_reset), 32'(m_cnt_reset));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("dbg_state_busy", 32'(dbg_state != 2'd0), 32'(m_owner >= 0));
      check("grant_onehot", 32'($onehot0(grant)), 32'd1);
      check("done_without_grant", 32'(|(done & ~grant)), 32'd0);
      if (grant != '0 && grant != prev_grant) begin
         gi = oh_idx(grant);
         grant_log.push_back(gi);
         grant_cyc[gi] = cyc;
         if (exp_q.size() == 0) timeout_fail("grant_event_unexpected");
         else begin
            e = exp_q.pop_front();
            check("grant_event_kind", 32'(e[EW-1]), 32'd0);
            check("grant_event_client", 32'(gi), 32'(e[S +: 3]));
         end
      end
      if (done != '0) begin
         di = oh_idx(done);
         done_seen++;
         if (exp_q.size() == 0) timeout_fail("done_event_unexpected");
         else begin
            e = exp_q.pop_front();
            check("done_event_kind", 32'(e[EW-1]), 32'd1);
            check("done_event_client", 32'(di), 32'(e[S +: 3]));
            check("done_count", 32'(prev_cnt), 32'(e[S-1:0]));
            check("done_latency", 32'(cyc - grant_cyc[di]), 32'(int'(e[S-1:0]) + 1));
         end
      end
      prev_grant = grant;
      prev_cnt = cnt_count;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_len(input int i, input int v);
      len[i*S +: S] = S'(v);
   endtask

   task automatic wait_grant(input int i, input int budget);
      int n = 0;
      while (grant[i] !== 1'b1 && n < budget) begin tick(); n++; end
      if (grant[i] !== 1'b1) timeout_fail("wait_grant");
   endtask

   task automatic wait_any_grant(input int budget);
      int n = 0;
      while (grant === '0 && n < budget) begin tick(); n++; end
      if (grant === '0) timeout_fail("wait_any_grant");
   endtask

   task automatic wait_done(input int i, input int budget);
      int n = 0;
      while (done[i] !== 1'b1 && n < budget) begin tick(); n++; end
      if (done[i] !== 1'b1) timeout_fail("wait_done");
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin tick(); n++; end
      if (busy !== 1'b0) timeout_fail("wait_idle");
   endtask

   function automatic int pick_len();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 0;
      if (r == 1) return 31;
      return $urandom_range(1, 8);
   endfunction

   int off [R];
   int cool [R];
   int n;

   initial begin
      // Reset with every request raised.
      reset = 1'b1;
      req = '1;
      for (int i = 0; i < R; i++) begin set_len(i, 1); off[i] = 0; cool[i] = 0; end
      repeat (3) tick();
      reset = 1'b0;
      grant_log.delete();

      // Round robin: drop on done, re-raise one cycle later.
      repeat (40) begin
         tick();
         for (int i = 0; i < R; i++) begin
            if (done[i]) begin req[i] = 1'b0; off[i] = 1; end
            else if (!req[i] && off[i] != 0) begin req[i] = 1'b1; off[i] = 0; end
         end
      end
      for (int k = 0; k < 8; k++) begin
         if (k < grant_log.size()) check("rr_order", 32'(grant_log[k]), 32'(k % R));
         else timeout_fail("rr_order");
      end
      req = '0;
      wait_idle(20);
      tick();

      // Single run of length 3 on client 0.
      set_len(0, 3);
      req[0] = 1'b1;
      wait_grant(0, 10);
      check("single_cnt_reset_low", 32'(cnt_reset), 32'd0);
      wait_done(0, 20);
      req[0] = 1'b0;
      tick();
      check("single_grant_fall", 32'(grant), 32'd0);
      check("single_busy_fall", 32'(busy), 32'd0);
      tick();

      // Abort of client 1 with client 2 pending.
      set_len(1, 10);
      req[1] = 1'b1;
      wait_grant(1, 10);
      set_len(2, 2);
      req[2] = 1'b1;
      repeat (4) tick();
      req[1] = 1'b0;
      tick();
      check("abort_grant", 32'(grant), 32'd0);
      check("abort_cnt_reset", 32'(cnt_reset), 32'd1);
      tick();
      check("abort_next_grant", 32'(grant), 32'b0100);
      wait_done(2, 20);
      req[2] = 1'b0;
      wait_idle(20);
      tick();

      // Length boundaries.
      set_len(3, 0);
      req[3] = 1'b1;
      wait_done(3, 10);
      req[3] = 1'b0;
      wait_idle(20);
      tick();
      set_len(3, 31);
      req[3] = 1'b1;
      wait_done(3, 60);
      req[3] = 1'b0;
      wait_idle(20);
      tick();

      // Reset in the middle of a run at count 5.
      set_len(3, 20);
      req[3] = 1'b1;
      wait_grant(3, 10);
      n = 0;
      while (cnt_count != S'(5) && n < 20) begin tick(); n++; end
      if (cnt_count != S'(5)) timeout_fail("wait_count5");
      reset = 1'b1;
      req[0] = 1'b1;
      set_len(0, 2);
      tick();
      reset = 1'b0;
      wait_any_grant(10);
      check("reset_first_grant", 32'(grant), 32'b0001);
      req = '0;
      wait_idle(60);
      tick();

      // Random traffic with aborts, sticky requests, len changes and reset pulses.
      for (int t = 0; t < 2000; t++) begin
         tick();
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 499) == 0) reset = 1'b1;
         for (int i = 0; i < R; i++) begin
            if (done[i]) begin
               if ($urandom_range(0, 7) != 0) req[i] = 1'b0;
               cool[i] = $urandom_range(0, 4);
            end else if (grant[i]) begin
               if ($urandom_range(0, 59) == 0) req[i] = 1'b0;
               else if ($urandom_range(0, 9) == 0) set_len(i, $urandom_range(0, 31));
            end else if (!req[i]) begin
               if (cool[i] > 0) cool[i]--;
               else if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  set_len(i, pick_len());
               end
            end
         end
      end
      reset = 1'b0;
      req = '0;
      wait_idle(80);
      repeat (3) tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("dones_observed", 32'(done_seen > 20), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/counter_run_arbiter.md
Name: counter_run_arbiter

Overview:
- Shares one `counter` instance between Requesters clients.
- Each client requests a timed run of programmable length. The block arbitrates round-robin and drives the counter's reset to start and stop it.
- It watches the counter's `count` output and signals completion per client.
- Sits beside the `counter` instance in the design: drives `counter.reset`, reads `counter.count`.

Parameters:
- Size, 5, width of the shared counter's count and of each run length.
- Requesters, 4, number of clients (2..8).

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  Requesters  per-client run request; level, held until done or abort.
- len  input  Requesters*Size  packed run lengths; client i at bits [i*Size +: Size].
- grant  output  Requesters  one-hot owner of the counter, registered.
- done  output  Requesters  one-cycle completion pulse to the owner, registered.
- busy  output  1  high whenever state != IDLE.
- cnt_reset  output  1  drives the shared counter's reset, registered.
- cnt_count  input  Size  the shared counter's count.

Behaviour:
- Counter contract:
  - When cnt_reset is high at a posedge, the counter loads 0.
  - Otherwise it increments by 1, mod 2^Size.
- Reset, sampled at posedge:
  - State goes to IDLE.
  - grant=0, done=0, busy=0, cnt_reset=1.
  - Round-robin pointer last=Requesters-1, so client 0 has first priority.
  - Reset overrides every other event, including mid-run.
- States: IDLE, RUN, DONE.
- IDLE:
  - cnt_reset=1, grant=0.
  - If any req bit is high, pick the first high bit searching last+1, last+2, … wrapping modulo Requesters.
  - At that edge: grant<=onehot(g), len_q<=len[g], cnt_reset<=0, state<=RUN, last<=g.
- RUN:
  - Compare the sampled cnt_count with len_q each edge.
  - If req[g]==0 (abort):
    - State goes to IDLE, grant<=0, cnt_reset<=1.
    - No done pulse.
    - Abort takes priority over a simultaneous length match.
  - Else if cnt_count==len_q:
    - State goes to DONE, done[g]<=1, cnt_reset<=1.
    - grant stays high.
  - Otherwise stay in RUN.
- DONE:
  - Lasts exactly one cycle; done[g]=1, grant still one-hot.
  - Next edge: state<=IDLE, done<=0, grant<=0.
  - The client must drop req on seeing done. If req stays high, the client is re-arbitrated from IDLE with lower priority, since last=g.
- Latency (grant is first visible after edge k):
  - done is visible after edge k+1+len, so grant-to-done is len+1 cycles.
  - grant falls after edge k+2+len.
  - Minimum request-to-request turnaround for a second client: 1 IDLE cycle after DONE.
- len_q is latched at grant; changes to len during RUN are ignored.
- len=0: done after 1 RUN cycle.
- len=2^Size-1: count reaches the value without wrapping.
- grant and done are always one-hot or zero; done is never high without the same grant bit.
- req bits of non-owners are ignored while busy.

Test Plan:
- Reset response:
  - Stimulus: hold reset high 3 cycles with all req high.
  - Required: grant=0, done=0, busy=0, cnt_reset=1 throughout.
  - After release: first grant=4'b0001.
- Single run:
  - Stimulus: req[0]=1, len[0]=3, grant after edge k.
  - Required: cnt_reset=0 from edge k; cnt_count visibly 0,1,2,3.
  - Required: done=4'b0001 after edge k+4 for exactly one cycle; grant and busy fall after edge k+5.
- Round-robin order:
  - Stimulus: all four req high, every len=1; each client drops req on done, re-raises 1 cycle later.
  - Required: grant sequence 0001, 0010, 0100, 1000, 0001.
  - Required: no client is granted twice before all others have been granted once.
- Abort:
  - Stimulus: req[1]=1, len[1]=10; drop req[1] 4 cycles after grant.
  - Required: next edge goes to IDLE with grant=0 and cnt_reset=1; done never asserted.
  - Required: a pending req[2] is granted on the following edge.
- Length boundaries:
  - Stimulus: len=0, then len=31 with Size=5.
  - Required: grant-to-done of 1 cycle and 32 cycles respectively.
  - Required: cnt_count seen at done = 0 and 31; no wrap to 0 before done.
- Reset mid-run:
  - Stimulus: assert reset in RUN at count=5 while req[3] and req[0] are high.
  - Required: next edge gives reset values and pointer last=3.
  - Required: after release, client 0 is granted first.
